sdram_init_gen: RTL and testbench

SDRAM_INIT_GEN -- requirements
Module: sdram_init_gen

---
 rtl/sdram_pkg.sv | 31 +++
 rtl/sdram_init_gen_if.sv | 36 +++
 rtl/sdram_tcnt.sv | 32 +++
 rtl/sdram_init_gen.sv | 184 ++++++++++++++++++
 tb/tb_sdram_init_gen.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM init definitions: command encodings, init FSM states
// and a small helper for sizing the gap counter.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PRE,
    S_AREF,
    S_LMR,
    S_EMRS,
    S_DONE
  } init_st_e;

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdram_init_gen_if.sv
// Init handshake and SDRAM command bus bundle.
// master: init generator (drives bus, status); slave: controller side.
interface sdram_init_gen_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQM_W  = 4
);
  logic              init_start;
  logic              init_busy;
  logic              init_end;
  logic              init_done;
  logic              init_cke;
  logic              init_cs_n;
  logic              init_ras_n;
  logic              init_cas_n;
  logic              init_we_n;
  logic [ADDR_W-1:0] init_addr;
  logic [BA_W-1:0]   init_ba;
  logic [DQM_W-1:0]  init_dqm;

  modport master (
    input  init_start,
    output init_busy, init_end, init_done,
    output init_cke, init_cs_n, init_ras_n,
    output init_cas_n, init_we_n,
    output init_addr, init_ba, init_dqm
  );

  modport slave (
    output init_start,
    input  init_busy, init_end, init_done,
    input  init_cke, init_cs_n, init_ras_n,
    input  init_cas_n, init_we_n,
    input  init_addr, init_ba, init_dqm
  );
endinterface

// File: rtl/sdram_tcnt.sv
// Loadable down-counter; tc pulses for one cycle when a loaded count
// expires. Ports: sclk, srst_n, load, load_val, tc.
module sdram_tcnt #(
  parameter int W = 4
) (
  input  logic         sclk,
  input  logic         srst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;
  logic         act;

  // Loading N makes tc fire N+1 cycles later; it stops at zero.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      cnt <= '0;
      act <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      act <= 1'b1;
    end else if (act) begin
      if (cnt == '0) act <= 1'b0;
      else           cnt <= cnt - W'(1);
    end
  end

  assign tc = act && (cnt == '0);

endmodule

// File: rtl/sdram_init_gen.sv
// SDRAM power-up init: WAIT, PRE, AREF x N, LMR, optional EMRS.
// Ports: sclk, srst_n, bus (master). Option: SDRAM_INIT_EMRS_EN.
module sdram_init_gen
  import sdram_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int BA_W     = 2,
  parameter int DQM_W    = 4,
  parameter int WAIT_CYC = 20000,
  parameter int T_RP     = 3,
  parameter int T_RFC    = 7,
  parameter int T_MRD    = 2,
  parameter int AREF_NUM = 8,
  parameter logic [ADDR_W-1:0] MODE_REG  = 'h030,
  parameter logic [ADDR_W-1:0] EMODE_REG = 'h000
) (
  input logic               sclk,
  input logic               srst_n,
  sdram_init_gen_if.master  bus
);

  localparam int MAXI = max4(WAIT_CYC, T_RP, T_RFC, T_MRD);
  localparam int TW   = $clog2(MAXI + 1);
  localparam int RW   = $clog2(AREF_NUM + 1);

  if (T_RP < 1 || T_RFC < 1 || T_MRD < 1 ||
      AREF_NUM < 1 || WAIT_CYC < 1 || ADDR_W < 11 ||
      $bits(EMODE_REG) != ADDR_W) begin : g_bad
    $error("sdram_init_gen: illegal parameters");
  end

  init_st_e          st, st_nx;
  logic [RW-1:0]     ref_cnt, ref_nx;
  logic [3:0]        cmd_q, cmd_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [BA_W-1:0]   ba_q, ba_nx;
  logic              cke_q, cke_nx;
  logic              busy_q, busy_nx;
  logic              end_q, end_nx;
  logic              done_q, done_nx;
  logic              ld, tc, go, fin;
  logic [TW-1:0]     ld_val;

  sdram_tcnt #(.W(TW)) u_tcnt (
    .sclk     (sclk),
    .srst_n   (srst_n),
    .load     (ld),
    .load_val (ld_val),
    .tc       (tc)
  );

  // Each gap of G cycles loads G-1 into the counter.
  always_comb begin
    st_nx   = st;
    ref_nx  = ref_cnt;
    cmd_nx  = CMD_NOP;
    addr_nx = '0;
    ba_nx   = '0;
    cke_nx  = 1'b1;
    busy_nx = busy_q;
    end_nx  = 1'b0;
    done_nx = done_q;
    ld      = 1'b0;
    ld_val  = '0;
    go      = 1'b0;
    fin     = 1'b0;
    unique case (st)
      S_IDLE: begin
        cmd_nx = CMD_DESEL;
        cke_nx = 1'b0;
        go     = bus.init_start;
      end
      S_DONE: begin
        cmd_nx = CMD_DESEL;
        go     = bus.init_start;
      end
      S_WAIT: begin
        if (tc) begin
          cmd_nx      = CMD_PRE;
          addr_nx[10] = 1'b1;
          st_nx       = S_PRE;
          ld          = 1'b1;
          ld_val      = TW'(T_RP - 1);
        end
      end
      S_PRE: begin
        if (tc) begin
          cmd_nx = CMD_AREF;
          ref_nx = RW'(1);
          st_nx  = S_AREF;
          ld     = 1'b1;
          ld_val = TW'(T_RFC - 1);
        end
      end
      S_AREF: begin
        if (tc) begin
          ld = 1'b1;
          if (ref_cnt == RW'(AREF_NUM)) begin
            cmd_nx  = CMD_LMR;
            addr_nx = MODE_REG;
            st_nx   = S_LMR;
            ld_val  = TW'(T_MRD - 1);
          end else begin
            cmd_nx = CMD_AREF;
            ref_nx = ref_cnt + RW'(1);
            ld_val = TW'(T_RFC - 1);
          end
        end
      end
`ifdef SDRAM_INIT_EMRS_EN
      S_LMR: begin
        if (tc) begin
          cmd_nx  = CMD_LMR;
          ba_nx   = BA_W'(2);
          addr_nx = EMODE_REG;
          st_nx   = S_EMRS;
          ld      = 1'b1;
          ld_val  = TW'(T_MRD - 1);
        end
      end
      S_EMRS: fin = tc;
`else
      S_LMR: fin = tc;
`endif
      default: st_nx = S_IDLE;
    endcase

    if (go) begin
      st_nx   = S_WAIT;
      ref_nx  = '0;
      cmd_nx  = CMD_NOP;
      cke_nx  = 1'b1;
      busy_nx = 1'b1;
      done_nx = 1'b0;
      ld      = 1'b1;
      ld_val  = TW'(WAIT_CYC - 1);
    end

    if (fin) begin
      st_nx   = S_DONE;
      cmd_nx  = CMD_DESEL;
      busy_nx = 1'b0;
      end_nx  = 1'b1;
      done_nx = 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      st      <= S_IDLE;
      ref_cnt <= '0;
      cmd_q   <= CMD_DESEL;
      addr_q  <= '0;
      ba_q    <= '0;
      cke_q   <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st      <= st_nx;
      ref_cnt <= ref_nx;
      cmd_q   <= cmd_nx;
      addr_q  <= addr_nx;
      ba_q    <= ba_nx;
      cke_q   <= cke_nx;
      busy_q  <= busy_nx;
      end_q   <= end_nx;
      done_q  <= done_nx;
    end
  end

  assign bus.init_cke   = cke_q;
  assign bus.init_cs_n  = cmd_q[3];
  assign bus.init_ras_n = cmd_q[2];
  assign bus.init_cas_n = cmd_q[1];
  assign bus.init_we_n  = cmd_q[0];
  assign bus.init_addr  = addr_q;
  assign bus.init_ba    = ba_q;
  assign bus.init_dqm   = {DQM_W{1'b1}};
  assign bus.init_busy  = busy_q;
  assign bus.init_end   = end_q;
  assign bus.init_done  = done_q;

endmodule

// File: tb/tb_sdram_init_gen.sv
// Scoreboard bench for sdram_init_gen (AREF_NUM=2 and AREF_NUM=1).
// Expected command/end events are queued; a monitor pops and compares.
module tb_sdram_init_gen;
  import sdram_pkg::*;

  localparam logic [12:0] EMODE = 13'h055;

  typedef struct packed {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        endp;
  } ev_t;

  logic sclk = 1'b0;
  logic srst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  qa[$];
  ev_t  qb[$];

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  sdram_init_gen_if #(.ADDR_W(13), .BA_W(2), .DQM_W(4)) ifa ();
  sdram_init_gen_if #(.ADDR_W(13), .BA_W(2), .DQM_W(4)) ifb ();

  sdram_init_gen #(
    .ADDR_W(13), .BA_W(2), .DQM_W(4), .WAIT_CYC(10),
    .T_RP(3), .T_RFC(7), .T_MRD(2), .AREF_NUM(2),
    .MODE_REG(13'h030), .EMODE_REG(EMODE)
  ) u_a (
    .sclk   (sclk),
    .srst_n (srst_n),
    .bus    (ifa)
  );

  sdram_init_gen #(
    .ADDR_W(13), .BA_W(2), .DQM_W(4), .WAIT_CYC(10),
    .T_RP(3), .T_RFC(7), .T_MRD(2), .AREF_NUM(1),
    .MODE_REG(13'h030), .EMODE_REG(EMODE)
  ) u_b (
    .sclk   (sclk),
    .srst_n (srst_n),
    .bus    (ifb)
  );

  function automatic ev_t mk(int c, logic [3:0] m,
                             logic [12:0] a, logic [1:0] b,
                             logic e);
    ev_t r;
    r.cyc  = c;
    r.cmd  = m;
    r.addr = a;
    r.ba   = b;
    r.endp = e;
    return r;
  endfunction

  task automatic push_a(input int t0);
    qa.push_back(mk(t0 + 11, CMD_PRE, 13'h400, 2'd0, 1'b0));
    qa.push_back(mk(t0 + 14, CMD_AREF, 13'h000, 2'd0, 1'b0));
    qa.push_back(mk(t0 + 21, CMD_AREF, 13'h000, 2'd0, 1'b0));
    qa.push_back(mk(t0 + 28, CMD_LMR, 13'h030, 2'd0, 1'b0));
`ifdef SDRAM_INIT_EMRS_EN
    qa.push_back(mk(t0 + 30, CMD_LMR, EMODE, 2'd2, 1'b0));
    qa.push_back(mk(t0 + 32, CMD_DESEL, 13'h000, 2'd0, 1'b1));
`else
    qa.push_back(mk(t0 + 30, CMD_DESEL, 13'h000, 2'd0, 1'b1));
`endif
  endtask

  task automatic push_b(input int t0);
    qb.push_back(mk(t0 + 11, CMD_PRE, 13'h400, 2'd0, 1'b0));
    qb.push_back(mk(t0 + 14, CMD_AREF, 13'h000, 2'd0, 1'b0));
    qb.push_back(mk(t0 + 21, CMD_LMR, 13'h030, 2'd0, 1'b0));
`ifdef SDRAM_INIT_EMRS_EN
    qb.push_back(mk(t0 + 23, CMD_LMR, EMODE, 2'd2, 1'b0));
    qb.push_back(mk(t0 + 25, CMD_DESEL, 13'h000, 2'd0, 1'b1));
`else
    qb.push_back(mk(t0 + 23, CMD_DESEL, 13'h000, 2'd0, 1'b1));
`endif
  endtask

  task automatic mon(input int which, input logic [3:0] m,
                     input logic [12:0] a, input logic [1:0] b,
                     input logic e);
    ev_t got;
    ev_t exp;
    bit  have;
    if ((m != CMD_NOP && m != CMD_DESEL) || e) begin
      got  = mk(cyc, m, a, b, e);
      have = 1'b0;
      exp  = '0;
      if (which == 0) begin
        if (qa.size() != 0) begin
          have = 1'b1;
          exp  = qa.pop_front();
        end
      end else begin
        if (qb.size() != 0) begin
          have = 1'b1;
          exp  = qb.pop_front();
        end
      end
      n_vec++;
      if (!have) begin
        n_err++;
        $display("FAIL unexpected_ev dut%0d got cyc=%0d cmd=%b addr=%h ba=%0d end=%b required no event",
                 which, got.cyc, got.cmd, got.addr, got.ba, got.endp);
      end else if (got !== exp) begin
        n_err++;
        $display("FAIL event dut%0d got cyc=%0d cmd=%b addr=%h ba=%0d end=%b required cyc=%0d cmd=%b addr=%h ba=%0d end=%b",
                 which, got.cyc, got.cmd, got.addr, got.ba, got.endp,
                 exp.cyc, exp.cmd, exp.addr, exp.ba, exp.endp);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge sclk);
      mon(0, {ifa.init_cs_n, ifa.init_ras_n, ifa.init_cas_n,
              ifa.init_we_n}, ifa.init_addr, ifa.init_ba,
          ifa.init_end);
      mon(1, {ifb.init_cs_n, ifb.init_ras_n, ifb.init_cas_n,
              ifb.init_we_n}, ifb.init_addr, ifb.init_ba,
          ifb.init_end);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d got %h required %h",
               nm, cyc, got, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge sclk);
  endtask

  function automatic logic [3:0] cmd_a();
    return {ifa.init_cs_n, ifa.init_ras_n, ifa.init_cas_n,
            ifa.init_we_n};
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, "_cke"}, ifa.init_cke, 0);
    chk({tag, "_cmd"}, cmd_a(), CMD_DESEL);
    chk({tag, "_addr"}, ifa.init_addr, 0);
    chk({tag, "_ba"}, ifa.init_ba, 0);
    chk({tag, "_dqm"}, ifa.init_dqm, 4'hF);
    chk({tag, "_busy"}, ifa.init_busy, 0);
    chk({tag, "_end"}, ifa.init_end, 0);
    chk({tag, "_done"}, ifa.init_done, 0);
  endtask

  initial begin
    int t0;
    int t1;
    int t2;
    int t3;
    ifa.init_start = 1'b0;
    ifb.init_start = 1'b0;
    repeat (2) @(negedge sclk);
    chk_rst("rst");
    srst_n = 1'b1;
    repeat (3) @(negedge sclk);
    chk("idle_cmd", cmd_a(), CMD_DESEL);
    chk("idle_cke", ifa.init_cke, 0);

    // run 1: both DUTs from IDLE
    t0 = cyc;
    ifa.init_start = 1'b1;
    ifb.init_start = 1'b1;
    push_a(t0);
    push_b(t0);
    @(negedge sclk);
    ifa.init_start = 1'b0;
    ifb.init_start = 1'b0;
    chk("wait_busy", ifa.init_busy, 1);
    chk("wait_cke", ifa.init_cke, 1);
    chk("wait_cmd", cmd_a(), CMD_NOP);
    chk("wait_done", ifa.init_done, 0);
`ifdef SDRAM_INIT_EMRS_EN
    wait_to(t0 + 31);
    chk("pre_end_busy", ifa.init_busy, 1);
    wait_to(t0 + 33);
`else
    wait_to(t0 + 29);
    chk("pre_end_busy", ifa.init_busy, 1);
    wait_to(t0 + 31);
`endif
    chk("done_lvl", ifa.init_done, 1);
    chk("done_busy", ifa.init_busy, 0);
    chk("done_end", ifa.init_end, 0);
    chk("done_cmd", cmd_a(), CMD_DESEL);
    chk("done_cke", ifa.init_cke, 1);
    chk("b_done", ifb.init_done, 1);

    // run 2: restart from DONE at cycle 40
    t1 = t0 + 40;
    wait_to(t1);
    ifa.init_start = 1'b1;
    push_a(t1);
    @(negedge sclk);
    ifa.init_start = 1'b0;
    chk("restart_done", ifa.init_done, 0);
    chk("restart_busy", ifa.init_busy, 1);

    // run 3: start pulses at +5 and +20 must be ignored
    t2 = t1 + 40;
    wait_to(t2);
    ifa.init_start = 1'b1;
    push_a(t2);
    @(negedge sclk);
    ifa.init_start = 1'b0;
    wait_to(t2 + 5);
    ifa.init_start = 1'b1;
    @(negedge sclk);
    ifa.init_start = 1'b0;
    wait_to(t2 + 20);
    ifa.init_start = 1'b1;
    @(negedge sclk);
    ifa.init_start = 1'b0;
    wait_to(t2 + 40);
    chk("run3_done", ifa.init_done, 1);

    // run 4: reset during refresh at cycle 17
    t3 = cyc;
    ifa.init_start = 1'b1;
    push_a(t3);
    @(negedge sclk);
    ifa.init_start = 1'b0;
    wait_to(t3 + 17);
    srst_n = 1'b0;
    qa.delete();
    @(negedge sclk);
    chk_rst("midrst");
    @(negedge sclk);
    srst_n = 1'b1;
    repeat (40) @(negedge sclk);
    chk("post_cmd", cmd_a(), CMD_DESEL);
    chk("post_cke", ifa.init_cke, 0);
    chk("post_busy", ifa.init_busy, 0);
    chk("post_done", ifa.init_done, 0);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
